// File: rtl/data_memory.sv
// Multi-cycle RV32IM data memory: byte/half/word loads and stores with a fixed
// access latency, holding BUSYWAIT high while the access is in flight.
module data_memory #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MEM_READ,
  input  logic        MEM_WRITE,
  input  logic [2:0]  FUNC3,
  input  logic [31:0] MEM_ADDRESS,
  input  logic [31:0] MEM_WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        BUSYWAIT,
  output logic        MISALIGNED
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW+1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic [2:0]      f3_q;
  logic            wr_q;
  logic [31:0]     mem_q [DEPTH_WORDS];
  logic [31:0]     rdata_q;

  logic            req;
  logic            fire;
  logic            illegal;
  logic [AW-1:0]   idx;
  logic [1:0]      lane;
  logic [31:0]     rword;
  logic [7:0]      rbyte;
  logic [15:0]     rhalf;
  logic [31:0]     load_val;
  logic [31:0]     wmerge;

  // Address bits above the memory size are ignored so accesses wrap.
  logic unused_addr;
  assign unused_addr = ^MEM_ADDRESS[31:AW+2];

  assign req  = MEM_READ | MEM_WRITE;
  assign fire = (state_q == ACCESS) && (cnt_q == '0);
  assign idx  = addr_q[AW+1:2];
  assign lane = addr_q[1:0];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = ACCESS;
        cnt_d   = CW'(LATENCY - 1);
      end
      ACCESS: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    BUSYWAIT   = ((state_q == IDLE) && req) || (state_q == ACCESS);
    MISALIGNED = (state_q == DONE) && illegal;
  end

  // Request fields are captured once; the request is held upstream but ignored afterwards.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      wr_q    <= 1'b0;
    end else if ((state_q == IDLE) && req) begin
      addr_q  <= MEM_ADDRESS[AW+1:0];
      wdata_q <= MEM_WRITE_DATA;
      f3_q    <= FUNC3;
      wr_q    <= MEM_WRITE;
    end
  end

  always_comb begin
    case (f3_q)
      3'b000, 3'b100: illegal = 1'b0;
      3'b001, 3'b101: illegal = addr_q[0];
      3'b010:         illegal = (addr_q[1:0] != 2'b00);
      default:        illegal = 1'b1;
    endcase
  end

  assign rword = mem_q[idx];
  assign rbyte = rword[{lane, 3'b000} +: 8];
  assign rhalf = lane[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    case (f3_q)
      3'b000:  load_val = {{24{rbyte[7]}}, rbyte};
      3'b100:  load_val = {24'h0, rbyte};
      3'b001:  load_val = {{16{rhalf[15]}}, rhalf};
      3'b101:  load_val = {16'h0, rhalf};
      default: load_val = rword;
    endcase
  end

  always_comb begin
    wmerge = rword;
    case (f3_q[1:0])
      2'b00:   wmerge[{lane, 3'b000} +: 8] = wdata_q[7:0];
      2'b01:   wmerge[{lane[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: wmerge = wdata_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= '0;
    end else if (fire && wr_q && !illegal) begin
      mem_q[idx] <= wmerge;
    end
  end

  // Stores (including read+write) leave the last load result untouched.
  always_ff @(posedge CLK) begin
    if (RESET)                rdata_q <= '0;
    else if (fire && !wr_q)   rdata_q <= illegal ? 32'h0 : load_val;
  end

  assign READ_DATA = rdata_q;

endmodule

// File: tb/tb_data_memory.sv
// Randomized and directed bench for data_memory against a byte-array reference model.
module tb_data_memory;

  localparam int DEPTH = 256;
  localparam int LAT   = 4;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        MEM_READ = 1'b0;
  logic        MEM_WRITE = 1'b0;
  logic [2:0]  FUNC3 = 3'd0;
  logic [31:0] MEM_ADDRESS = '0;
  logic [31:0] MEM_WRITE_DATA = '0;
  logic [31:0] READ_DATA;
  logic        BUSYWAIT;
  logic        MISALIGNED;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  ref_mem [DEPTH*4];
  logic [31:0] ref_rd;

  data_memory #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .FUNC3(FUNC3), .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITE_DATA(MEM_WRITE_DATA),
    .READ_DATA(READ_DATA), .BUSYWAIT(BUSYWAIT), .MISALIGNED(MISALIGNED)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    bit          mis;
  } step_t;

  task automatic model_clear();
    for (int i = 0; i < DEPTH*4; i++) ref_mem[i] = 8'h00;
    ref_rd = 32'h0;
  endtask

  // Byte-addressed view of memory; loads assemble bytes numerically and extend.
  task automatic model(input bit rd, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] e_rd, output bit e_mis);
    int size; bit ill; longint v; int base;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    ill  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || ((a % size) != 0);
    base = int'(a[9:0]);
    if (wr) begin
      if (!ill) for (int i = 0; i < size; i++) ref_mem[base+i] = d[8*i +: 8];
    end else if (ill) begin
      ref_rd = 32'h0;
    end else begin
      v = 0;
      for (int i = size-1; i >= 0; i--) v = v*256 + longint'(ref_mem[base+i]);
      if (!f3[2] && size < 4 && v >= (longint'(1) << (8*size-1)))
        v -= (longint'(1) << (8*size));
      ref_rd = v[31:0];
    end
    e_rd  = ref_rd;
    e_mis = ill;
    if (rd && wr) e_mis = ill;
  endtask

  // Starts at posedge+1, returns at posedge+1 after the DONE cycle.
  task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        output int busy, output logic [31:0] rdat,
                        output logic mis, output bit tout);
    MEM_READ = rd; MEM_WRITE = wr; FUNC3 = f3; MEM_ADDRESS = a; MEM_WRITE_DATA = d;
    busy = 0; tout = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (BUSYWAIT) busy++;
      else begin tout = 1'b0; break; end
    end
    rdat = READ_DATA; mis = MISALIGNED;
    @(posedge CLK); #1;
    MEM_READ = 1'b0; MEM_WRITE = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    model_clear();
    @(negedge CLK);
    n_tests++;
    if (BUSYWAIT !== 1'b0 || READ_DATA !== 32'h0 || MISALIGNED !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b rd=%h mis=%b required 0/00000000/0", BUSYWAIT, READ_DATA, MISALIGNED);
    end
    @(posedge CLK); #1 MEM_READ = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (BUSYWAIT !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_comb_idle: busy=%b required 1", BUSYWAIT);
    end
    MEM_READ = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_directed();
    step_t tbl[16];
    int busy; logic [31:0] rdat, e_rd; logic mis; bit tout, e_mis;
    tbl[0]  = '{0, 1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h00000000, 0};
    tbl[1]  = '{1, 0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 0};
    tbl[2]  = '{1, 0, 3'd0, 32'h11, 32'h0,        32'hFFFFFFBE, 0};
    tbl[3]  = '{1, 0, 3'd4, 32'h11, 32'h0,        32'h000000BE, 0};
    tbl[4]  = '{1, 0, 3'd1, 32'h12, 32'h0,        32'hFFFFDEAD, 0};
    tbl[5]  = '{1, 0, 3'd5, 32'h12, 32'h0,        32'h0000DEAD, 0};
    tbl[6]  = '{0, 1, 3'd0, 32'h13, 32'h12,       32'h0000DEAD, 0};
    tbl[7]  = '{1, 0, 3'd2, 32'h10, 32'h0,        32'h12ADBEEF, 0};
    tbl[8]  = '{0, 1, 3'd1, 32'h10, 32'h5678,     32'h12ADBEEF, 0};
    tbl[9]  = '{1, 0, 3'd2, 32'h10, 32'h0,        32'h12AD5678, 0};
    tbl[10] = '{1, 0, 3'd2, 32'h11, 32'h0,        32'h00000000, 1};
    tbl[11] = '{0, 1, 3'd1, 32'h13, 32'hFFFF,     32'h00000000, 1};
    tbl[12] = '{1, 0, 3'd2, 32'h10, 32'h0,        32'h12AD5678, 0};
    tbl[13] = '{1, 1, 3'd0, 32'h14, 32'h77,       32'h12AD5678, 0};
    tbl[14] = '{1, 0, 3'd4, 32'h14, 32'h0,        32'h00000077, 0};
    tbl[15] = '{1, 0, 3'd3, 32'h10, 32'h0,        32'h00000000, 1};
    for (int s = 0; s < 16; s++) begin
      model(tbl[s].rd, tbl[s].wr, tbl[s].f3, tbl[s].a, tbl[s].d, e_rd, e_mis);
      access(tbl[s].rd, tbl[s].wr, tbl[s].f3, tbl[s].a, tbl[s].d, busy, rdat, mis, tout);
      n_tests++;
      if (tout || busy != LAT+1) begin
        n_fail++;
        $display("FAIL dir%0d_busy: cycles=%0d timeout=%b required %0d", s, busy, tout, LAT+1);
      end
      n_tests++;
      if (rdat !== tbl[s].exp) begin
        n_fail++;
        $display("FAIL dir%0d_rdata: got %h required %h", s, rdat, tbl[s].exp);
      end
      n_tests++;
      if (mis !== tbl[s].mis) begin
        n_fail++;
        $display("FAIL dir%0d_misaligned: got %b required %b", s, mis, tbl[s].mis);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    int busy; logic [31:0] rdat; logic mis; bit tout;
    MEM_WRITE = 1'b1; FUNC3 = 3'd2; MEM_ADDRESS = 32'h20; MEM_WRITE_DATA = 32'hFFFFFFFF;
    @(posedge CLK);
    @(posedge CLK); #1;
    RESET = 1'b1; MEM_WRITE = 1'b0;
    @(posedge CLK); #1 RESET = 1'b0;
    model_clear();
    @(negedge CLK);
    n_tests++;
    if (BUSYWAIT !== 1'b0 || READ_DATA !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset_idle: busy=%b rd=%h required 0/00000000", BUSYWAIT, READ_DATA);
    end
    @(posedge CLK); #1;
    access(1, 0, 3'd2, 32'h20, 32'h0, busy, rdat, mis, tout);
    n_tests++;
    if (tout || rdat !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset_store_dropped: got %h timeout=%b required 00000000", rdat, tout);
    end
    access(1, 0, 3'd2, 32'h10, 32'h0, busy, rdat, mis, tout);
    n_tests++;
    if (tout || rdat !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset_mem_cleared: got %h timeout=%b required 00000000", rdat, tout);
    end
  endtask

  task automatic test_back_to_back();
    int busy1, busy2; logic [31:0] r1, r2, e_rd; logic m1, m2; bit t1, t2, e_mis;
    model(0, 1, 3'd2, 32'h400, 32'hA5A5A5A5, e_rd, e_mis);
    access(0, 1, 3'd2, 32'h400, 32'hA5A5A5A5, busy1, r1, m1, t1);
    model(1, 0, 3'd2, 32'h0, 32'h0, e_rd, e_mis);
    access(1, 0, 3'd2, 32'h0, 32'h0, busy2, r2, m2, t2);
    n_tests++;
    if (t1 || t2 || busy1 != LAT+1 || busy2 != LAT+1) begin
      n_fail++;
      $display("FAIL b2b_busy: cycles=%0d/%0d required %0d/%0d", busy1, busy2, LAT+1, LAT+1);
    end
    n_tests++;
    if (r2 !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL wrap_load: got %h required a5a5a5a5", r2);
    end
  endtask

  task automatic test_random();
    logic [2:0] f3_tbl [8];
    logic [2:0] f3; logic [31:0] a, d, rdat, e_rd; logic mis; bit rd, wr, e_mis, tout;
    int busy, pick;
    f3_tbl[0] = 3'd0; f3_tbl[1] = 3'd1; f3_tbl[2] = 3'd2; f3_tbl[3] = 3'd4;
    f3_tbl[4] = 3'd5; f3_tbl[5] = 3'd2; f3_tbl[6] = 3'd3; f3_tbl[7] = 3'd7;
    for (int n = 0; n < 80; n++) begin
      pick = $urandom_range(0, 9);
      rd = (pick < 5) || (pick == 9);
      wr = (pick >= 5);
      f3 = f3_tbl[$urandom_range(0, 7)];
      a  = ($urandom & 32'hFFFFFC00) | 32'($urandom_range(0, 47));
      d  = $urandom;
      model(rd, wr, f3, a, d, e_rd, e_mis);
      access(rd, wr, f3, a, d, busy, rdat, mis, tout);
      n_tests++;
      if (tout || busy != LAT+1 || rdat !== e_rd || mis !== e_mis) begin
        n_fail++;
        $display("FAIL rand%0d: op=%b%b f3=%0d a=%h busy=%0d rd=%h mis=%b required busy=%0d rd=%h mis=%b",
                 n, rd, wr, f3, a, busy, rdat, mis, LAT+1, e_rd, e_mis);
      end
      repeat ($urandom_range(0, 2)) @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_directed();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
